micro_sequencer_p: RTL
======================

# micro_sequencer_p

Parametrised microprogram sequencer for the multi-cycle CPU family: the next generation of the fixed microcontroller.
- Holds a writable microstore and two opcode dispatch tables, and steps a micro-PC.
- Emits a CTRL_W-bit control word each cycle.
- Adds behaviour the fixed controller lacks: stalling on memory-not-ready (MIO_ready), interrupt entry at instruction boundaries, and illegal-opcode trapping.
- Sits between IR/MIO handshake signals and the datapath control mux selects.

## Interface
Parameters:
- CTRL_W, 24, control-field width driven to the datapath
- UADDR_W, 5, micro-PC width; microstore depth 2^UADDR_W
- OPCODE_W, 6, dispatch index width; each dispatch table has 2^OPCODE_W entries
- PROG_AW, 6, load-port address width; must be ≥ max(UADDR_W, OPCODE_W)
- INT_VEC, 30, micro-address of the interrupt entry routine
- ILL_VEC, 31, micro-address of the illegal-opcode routine

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- opcode  in  OPCODE_W  dispatch index, taken from IR
- MIO_ready  in  1  memory ready; sampled only in wait microinstructions
- INT  in  1  level interrupt request
- int_en  in  1  interrupt enable; masks taking, not latching
- prog_we  in  1  load-port write strobe
- prog_sel  in  2  0 = microstore, 1 = dispatch table 1, 2 = dispatch table 2, 3 = ignored
- prog_addr  in  PROG_AW  load address; upper bits beyond target depth ignored
- prog_data  in  CTRL_W+3  microword, or {valid, target uaddr} in the low UADDR_W+1 bits for dispatch tables
- ctrl  out  CTRL_W  control field of the current microword
- state  out  UADDR_W  current micro-PC
- mem_wait  out  1  current cycle is stalled on memory
- int_ack  out  1  one-cycle pulse on the first cycle at INT_VEC
- illegal  out  1  one-cycle pulse on the first cycle at ILL_VEC via an invalid dispatch

## Operation
- Microword layout: [CTRL_W-1:0] ctrl, [CTRL_W+1:CTRL_W] seq, [CTRL_W+2] wait.
- seq encoding: 0 = next (uPC+1), 1 = dispatch 1, 2 = dispatch 2, 3 = fetch (return to 0).
- ctrl and state are combinational from the uPC register and the microstore read.
- mem_wait = wait & ~MIO_ready. While mem_wait is high, uPC holds and no other sequencing occurs.
- Next uPC when not stalled:
  - seq 0: uPC+1, wrapping 2^UADDR_W-1 → 0.
  - seq 1/2: look up table[opcode]. If the entry's valid bit is 1, go to its target. If 0, go to ILL_VEC and pulse illegal.
  - seq 3: if (INT | int_pend) & int_en, go to INT_VEC, clear int_pend, pulse int_ack. Otherwise go to 0.
- int_pend:
  - Set on any cycle with INT=1, regardless of int_en.
  - Cleared only when the interrupt is taken or on reset.
  - INT asserted in the same cycle as a seq-3 boundary is taken immediately.
- Load port:
  - A write lands at the clock edge.
  - Reads see the new value from the next cycle onward, including a write to the current uPC.
  - prog_sel 3 writes nothing.
- Priority: reset > memory stall > sequencing.

## Timing
- Reset values:
  - uPC = 0, so state = 0.
  - int_pend = 0; int_ack = 0; illegal = 0.
  - ctrl = microstore[0][CTRL_W-1:0].
  - mem_wait = microstore[0].wait & ~MIO_ready.
- Reset does not clear the microstore or dispatch tables; contents persist across reset.
- Reset asserted mid-stall or mid-dispatch: the next cycle has uPC = 0, and no int_ack or illegal pulse.
- Sequencing latency: one cycle per microinstruction; a dispatch resolves in one cycle.
- int_ack and illegal are registered. Each is high exactly the cycle uPC first equals the vector after a trap transition. They are not high on plain sequential arrival at the same address.
- Stall length is unbounded. The cycle MIO_ready rises, that wait microinstruction completes and advances at the next edge.
- Microstore and dispatch tables are write-synchronous, read-asynchronous (distributed RAM); target ~300 lines of RTL.

## Test plan
- Reset, then load microwords 0..3 with seq=0,0,0,3 and ctrl=0xA,0xB,0xC,0xD → state cycles 0,1,2,3,0 and ctrl cycles 0xA,0xB,0xC,0xD,0xA; int_ack and illegal stay 0.
- Word 0 with wait=1, MIO_ready=0 for 4 cycles, then 1 → mem_wait=1 for 4 cycles, state stays 0 for 5 cycles total, then 1.
- Dispatch 1 at uPC 1, table1[0x23] = {1, 5'd6}, opcode=0x23 → next state=6. Set opcode=0x3F with entry valid=0 → next state=31 and illegal=1 for one cycle.
- INT pulsed for 1 cycle with int_en=0, then int_en=1 before the seq=3 word → at the boundary state=30 and int_ack=1 for one cycle. The next boundary returns to 0, since pend has cleared.
- INT=1 in the same cycle as a seq=3 word with int_en=1 → next state=30. Wrap check: seq=0 at uPC 31 → next state=0.
- Reset asserted while stalled at uPC 7 → next cycle state=0 and int_ack=illegal=0; microstore contents are unchanged afterward.

Source files
------------

// File: rtl/micro_sequencer_p.sv
// Writable-microstore sequencer: steps a micro-PC through a loadable microprogram with two
// opcode dispatch tables, memory-ready stalls, interrupt entry at fetch and illegal-opcode traps.
module micro_sequencer_p #(
  parameter int unsigned CTRL_W   = 24,
  parameter int unsigned UADDR_W  = 5,
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned PROG_AW  = 6,
  parameter int unsigned INT_VEC  = 30,
  parameter int unsigned ILL_VEC  = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                MIO_ready,
  input  logic                INT,
  input  logic                int_en,
  input  logic                prog_we,
  input  logic [1:0]          prog_sel,
  input  logic [PROG_AW-1:0]  prog_addr,
  input  logic [CTRL_W+2:0]   prog_data,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [UADDR_W-1:0]  state,
  output logic                mem_wait,
  output logic                int_ack,
  output logic                illegal
);

  localparam int unsigned UDepth = 1 << UADDR_W;
  localparam int unsigned DDepth = 1 << OPCODE_W;
  localparam int unsigned MwW    = CTRL_W + 3;
  localparam logic [UADDR_W-1:0] IntVec = UADDR_W'(INT_VEC);
  localparam logic [UADDR_W-1:0] IllVec = UADDR_W'(ILL_VEC);

  typedef enum logic [1:0] {
    SeqNext  = 2'd0,
    SeqDisp1 = 2'd1,
    SeqDisp2 = 2'd2,
    SeqFetch = 2'd3
  } seq_e;

  // Distributed-RAM style storage: no reset, contents survive reset.
  logic [MwW-1:0]     ustore [UDepth];
  logic [UADDR_W:0]   disp1  [DDepth];
  logic [UADDR_W:0]   disp2  [DDepth];

  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               int_pend_q, int_pend_d;
  logic               int_ack_q, int_ack_d;
  logic               illegal_q, illegal_d;

  logic [MwW-1:0]     uword;
  seq_e               seq;
  logic               wait_bit;
  logic [UADDR_W:0]   disp_entry;

  always_ff @(posedge clk) begin
    if (prog_we) begin
      case (prog_sel)
        2'd0:    ustore[prog_addr[UADDR_W-1:0]] <= prog_data;
        2'd1:    disp1[prog_addr[OPCODE_W-1:0]] <= prog_data[UADDR_W:0];
        2'd2:    disp2[prog_addr[OPCODE_W-1:0]] <= prog_data[UADDR_W:0];
        default: ;
      endcase
    end
  end

  assign uword      = ustore[upc_q];
  assign seq        = seq_e'(uword[CTRL_W+1:CTRL_W]);
  assign wait_bit   = uword[CTRL_W+2];
  assign disp_entry = (seq == SeqDisp2) ? disp2[opcode] : disp1[opcode];

  assign mem_wait = wait_bit & ~MIO_ready;
  assign ctrl     = uword[CTRL_W-1:0];
  assign state    = upc_q;
  assign int_ack  = int_ack_q;
  assign illegal  = illegal_q;

  always_comb begin
    upc_d      = upc_q;
    int_ack_d  = 1'b0;
    illegal_d  = 1'b0;
    // Requests latch even while stalled or masked.
    int_pend_d = int_pend_q | INT;
    if (!mem_wait) begin
      unique case (seq)
        SeqNext: upc_d = upc_q + UADDR_W'(1);
        SeqDisp1, SeqDisp2: begin
          if (disp_entry[UADDR_W]) begin
            upc_d = disp_entry[UADDR_W-1:0];
          end else begin
            upc_d     = IllVec;
            illegal_d = 1'b1;
          end
        end
        SeqFetch: begin
          if ((INT | int_pend_q) & int_en) begin
            upc_d      = IntVec;
            int_ack_d  = 1'b1;
            int_pend_d = 1'b0;
          end else begin
            upc_d = '0;
          end
        end
        default: upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q      <= '0;
      int_pend_q <= 1'b0;
      int_ack_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      upc_q      <= upc_d;
      int_pend_q <= int_pend_d;
      int_ack_q  <= int_ack_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule
